// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Shares one registered-output 32-bit ALU between two requesters. Each
//   requester owns a small FIFO; a round-robin arbiter issues at most one op
//   per cycle into the ALU, and the ALU's registered result is presented on a
//   single valid/ready result port tagged with requester index and op tag.
//
// Ports
//   clk, reset (async, active low), flush (sync drop of queued ops)
//   req_valid/req_ready/req_func/req_a/req_b/req_sh/req_tag : two packed request lanes
//   alu_allow/alu_func/alu_in0/alu_in1/alu_c0               : ALU issue side
//   alu_result/alu_carry/alu_exc                            : ALU registered outputs
//   res_valid/res_ready/res_src/res_tag/res_data/res_carry/res_exc : result port
//   exc_seen                                                : sticky exception flag
module alu_issue_arbiter #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [11:0]          req_func,
    input  logic [63:0]          req_a,
    input  logic [63:0]          req_b,
    input  logic [9:0]           req_sh,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic                 alu_allow,
    output logic [5:0]           alu_func,
    output logic [31:0]          alu_in0,
    output logic [31:0]          alu_in1,
    output logic [4:0]           alu_c0,
    input  logic [31:0]          alu_result,
    input  logic                 alu_carry,
    input  logic [3:0]           alu_exc,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_src,
    output logic [TAG_W-1:0]     res_tag,
    output logic [31:0]          res_data,
    output logic                 res_carry,
    output logic [3:0]           res_exc,
    output logic                 exc_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [5:0]       func;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [4:0]       sh;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem_q [2][DEPTH];
    entry_t           mem_d [2][DEPTH];
    logic [AW:0]      wr_ptr_q [2];
    logic [AW:0]      wr_ptr_d [2];
    logic [AW:0]      rd_ptr_q [2];
    logic [AW:0]      rd_ptr_d [2];
    logic             rr_q, rr_d;
    logic             res_valid_q, res_valid_d;
    logic             res_src_q, res_src_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             exc_seen_q, exc_seen_d;

    entry_t           in_entry_s [2];
    entry_t           head_s;
    logic [1:0]       empty_s;
    logic [1:0]       full_s;
    logic [1:0]       push_s;
    logic             slot_free_s;
    logic             issue_s;
    logic             grant_s;

    // FIFO status, lane unpacking and arbitration decision
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            empty_s[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            // Same slot index but different wrap bit means the FIFO is full.
            full_s[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                         (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            // Flush-cycle pushes are dropped, so they are never accepted.
            push_s[i]  = req_valid[i] & ~full_s[i] & ~flush;
            in_entry_s[i].func = req_func[i*6 +: 6];
            in_entry_s[i].a    = req_a[i*32 +: 32];
            in_entry_s[i].b    = req_b[i*32 +: 32];
            in_entry_s[i].sh   = req_sh[i*5 +: 5];
            in_entry_s[i].tag  = req_tag[i*TAG_W +: TAG_W];
        end
        slot_free_s = ~res_valid_q | res_ready;
        issue_s     = slot_free_s & (empty_s != 2'b11) & ~flush;
        if (!empty_s[0] && !empty_s[1]) begin
            grant_s = rr_q;
        end else if (!empty_s[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        head_s = mem_q[grant_s][rd_ptr_q[grant_s][AW-1:0]];
    end

    // FIFO storage and pointer next-state
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                rd_ptr_d[i] = wr_ptr_q[i];
            end else begin
                if (push_s[i]) begin
                    mem_d[i][wr_ptr_q[i][AW-1:0]] = in_entry_s[i];
                    wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
                end else begin
                    wr_ptr_d[i] = wr_ptr_q[i];
                end
                if (issue_s && (grant_s == i[0])) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
                end else begin
                    rd_ptr_d[i] = rd_ptr_q[i];
                end
            end
        end
    end

    // Result slot, round-robin pointer and sticky exception next-state
    always_comb begin
        rr_d        = rr_q;
        res_valid_d = res_valid_q;
        res_src_d   = res_src_q;
        res_tag_d   = res_tag_q;
        if (issue_s) begin
            res_valid_d = 1'b1;
            res_src_d   = grant_s;
            res_tag_d   = head_s.tag;
            rr_d        = ~grant_s;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
        exc_seen_d = exc_seen_q | (res_valid_q & res_ready & (alu_exc != 4'b0000));
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            rr_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_src_q   <= 1'b0;
            res_tag_q   <= '0;
            exc_seen_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_q        <= rr_d;
            res_valid_q <= res_valid_d;
            res_src_q   <= res_src_d;
            res_tag_q   <= res_tag_d;
            exc_seen_q  <= exc_seen_d;
        end
    end

    // The ALU captures only on allow; buses idle at zero otherwise.
    assign alu_allow = issue_s;
    assign alu_func  = issue_s ? head_s.func : 6'd0;
    assign alu_in0   = issue_s ? head_s.a    : 32'd0;
    assign alu_in1   = issue_s ? head_s.b    : 32'd0;
    assign alu_c0    = issue_s ? head_s.sh   : 5'd0;

    assign req_ready = ~full_s;
    assign res_valid = res_valid_q;
    assign res_src   = res_src_q;
    assign res_tag   = res_tag_q;
    // The ALU holds its output while allow is low, so these stay stable under stall.
    assign res_data  = alu_result;
    assign res_carry = alu_carry;
    assign res_exc   = alu_exc;
    assign exc_seen  = exc_seen_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic         clk, reset, flush;
    logic [1:0]   req_valid, req_ready;
    logic [11:0]  req_func;
    logic [63:0]  req_a, req_b;
    logic [9:0]   req_sh;
    logic [7:0]   req_tag;
    logic         alu_allow;
    logic [5:0]   alu_func;
    logic [31:0]  alu_in0, alu_in1;
    logic [4:0]   alu_c0;
    logic [31:0]  alu_result;
    logic         alu_carry;
    logic [3:0]   alu_exc;
    logic         res_valid, res_ready, res_src;
    logic [3:0]   res_tag;
    logic [31:0]  res_data;
    logic         res_carry;
    logic [3:0]   res_exc;
    logic         exc_seen;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_a(req_a), .req_b(req_b), .req_sh(req_sh), .req_tag(req_tag),
        .alu_allow(alu_allow), .alu_func(alu_func), .alu_in0(alu_in0),
        .alu_in1(alu_in1), .alu_c0(alu_c0), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_exc(alu_exc), .res_valid(res_valid),
        .res_ready(res_ready), .res_src(res_src), .res_tag(res_tag),
        .res_data(res_data), .res_carry(res_carry), .res_exc(res_exc),
        .exc_seen(exc_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 1=ADD (exc[0]=signed overflow), 2=SUB (carry=borrow), 3=AND, 4=SLL by c0
    function automatic logic [36:0] alu_ref(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        logic [32:0] s;
        logic [31:0] d;
        logic        c;
        logic [3:0]  e;
        d = 32'd0; c = 1'b0; e = 4'd0;
        case (f)
            6'd1: begin
                s = {1'b0, a} + {1'b0, b};
                d = s[31:0];
                c = s[32];
                e = {3'b000, (a[31] == b[31]) && (d[31] != a[31])};
            end
            6'd2: begin d = a - b; c = (a < b); end
            6'd3: d = a & b;
            6'd4: d = a << sh;
            default: d = 32'd0;
        endcase
        return {e, c, d};
    endfunction

    // Registered-output ALU model: captures only while allow is high
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            {alu_exc, alu_carry, alu_result} <= 37'd0;
        end else if (alu_allow) begin
            {alu_exc, alu_carry, alu_result} <= alu_ref(alu_func, alu_in0, alu_in1, alu_c0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [3:0]  tag;
    } op_t;

    function automatic op_t lane_op(input int r);
        op_t o;
        o.func = req_func[r*6 +: 6];
        o.a    = req_a[r*32 +: 32];
        o.b    = req_b[r*32 +: 32];
        o.sh   = req_sh[r*5 +: 5];
        o.tag  = req_tag[r*4 +: 4];
        return o;
    endfunction

    task automatic set_lane(input int r, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh, input logic [3:0] tag);
        req_func[r*6 +: 6] = f;
        req_a[r*32 +: 32]  = a;
        req_b[r*32 +: 32]  = b;
        req_sh[r*5 +: 5]   = sh;
        req_tag[r*4 +: 4]  = tag;
    endtask

    // ---------------- scoreboard / reference model ----------------
    op_t        pend0[$];
    op_t        pend1[$];
    op_t        inflight, m_hd;
    logic       inf_src, exp_rv, rr_m, exc_m;
    logic       m_ne0, m_ne1, m_iss, m_g, m_acc, m_p0, m_p1;
    logic [36:0] m_r;

    always @(negedge clk) begin
        if (!reset) begin
            pend0.delete(); pend1.delete();
            exp_rv = 1'b0; rr_m = 1'b0; exc_m = 1'b0; inf_src = 1'b0;
        end else begin
            m_ne0 = (pend0.size() > 0);
            m_ne1 = (pend1.size() > 0);
            m_iss = (!exp_rv || res_ready) && (m_ne0 || m_ne1) && !flush;
            check("sb_alu_allow", alu_allow, m_iss);
            if (m_iss) begin
                m_g = (m_ne0 && m_ne1) ? rr_m : m_ne1;
                if (m_g) m_hd = pend1[0];
                else     m_hd = pend0[0];
                check("sb_alu_func", alu_func, m_hd.func);
                check("sb_alu_in0", alu_in0, m_hd.a);
                check("sb_alu_in1", alu_in1, m_hd.b);
                check("sb_alu_c0", alu_c0, m_hd.sh);
            end else begin
                check("sb_alu_idle", {alu_func, alu_c0, alu_in0 | alu_in1}, 64'd0);
            end
            check("sb_res_valid", res_valid, exp_rv);
            if (exp_rv) begin
                m_r = alu_ref(inflight.func, inflight.a, inflight.b, inflight.sh);
                check("sb_res_src", res_src, inf_src);
                check("sb_res_tag", res_tag, inflight.tag);
                check("sb_res_data", res_data, m_r[31:0]);
                check("sb_res_carry", res_carry, m_r[32]);
                check("sb_res_exc", res_exc, m_r[36:33]);
            end
            check("sb_exc_seen", exc_seen, exc_m);
            check("sb_req_ready", req_ready, {pend1.size() < DEPTH, pend0.size() < DEPTH});
            // advance the model to the state after the coming edge
            m_acc = exp_rv && res_ready;
            if (m_acc && (m_r[36:33] != 4'd0)) exc_m = 1'b1;
            m_p0 = req_valid[0] && (pend0.size() < DEPTH) && !flush;
            m_p1 = req_valid[1] && (pend1.size() < DEPTH) && !flush;
            if (m_iss) begin
                if (m_g) void'(pend1.pop_front());
                else     void'(pend0.pop_front());
                inflight = m_hd; inf_src = m_g; rr_m = !m_g; exp_rv = 1'b1;
            end else if (m_acc) begin
                exp_rv = 1'b0;
            end
            if (flush) begin
                pend0.delete(); pend1.delete();
            end
            if (m_p0) pend0.push_back(lane_op(0));
            if (m_p1) pend1.push_back(lane_op(1));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          r;
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [3:0]  tag;
        logic [31:0] d;
        logic        c;
        logic [3:0]  e;
    } vec_t;

    vec_t vt[6];
    int   cnt, cnt1, first, last;
    logic [7:0]  pat;
    logic [15:0] tags;

    initial begin
        vt[0] = '{0, 6'd1, 32'd7,          32'd5,          5'd0,  4'd3,  32'd12,         1'b0, 4'd0};
        vt[1] = '{1, 6'd2, 32'd5,          32'd7,          5'd0,  4'd9,  32'hFFFFFFFE,   1'b1, 4'd0};
        vt[2] = '{0, 6'd3, 32'h0000F0F0,   32'h0000FF00,   5'd0,  4'd4,  32'h0000F000,   1'b0, 4'd0};
        vt[3] = '{1, 6'd4, 32'd1,          32'd0,          5'd31, 4'd6,  32'h80000000,   1'b0, 4'd0};
        vt[4] = '{0, 6'd1, 32'hFFFFFFFF,   32'd1,          5'd0,  4'd2,  32'd0,          1'b1, 4'd0};
        vt[5] = '{1, 6'd1, 32'h7FFFFFFF,   32'd1,          5'd0,  4'd11, 32'h80000000,   1'b0, 4'd1};

        reset = 1'b0; flush = 1'b0; req_valid = 2'b00; res_ready = 1'b1;
        req_func = '0; req_a = '0; req_b = '0; req_sh = '0; req_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_alu_allow", alu_allow, 1'b0);
        check("rst_req_ready", req_ready, 2'b11);
        check("rst_res_src", res_src, 1'b0);
        check("rst_res_tag", res_tag, 4'd0);
        check("rst_exc_seen", exc_seen, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        // table: single ops with fixed latency (issue +1 cycle, result +2)
        for (int v = 0; v < 6; v++) begin
            set_lane(vt[v].r, vt[v].f, vt[v].a, vt[v].b, vt[v].sh, vt[v].tag);
            req_valid = (vt[v].r == 1) ? 2'b10 : 2'b01;
            @(posedge clk); #1;
            req_valid = 2'b00;
            @(negedge clk);
            check("tbl_allow", alu_allow, 1'b1);
            check("tbl_func", alu_func, vt[v].f);
            @(negedge clk);
            check("tbl_res_valid", res_valid, 1'b1);
            check("tbl_res_src", res_src, vt[v].r[0]);
            check("tbl_res_tag", res_tag, vt[v].tag);
            check("tbl_res_data", res_data, vt[v].d);
            check("tbl_res_carry", res_carry, vt[v].c);
            check("tbl_res_exc", res_exc, vt[v].e);
            @(posedge clk); #1;
        end
        check("exc_seen_set", exc_seen, 1'b1);

        // contention: 4 ops each, alternating grants, 8 back-to-back results
        cnt = 0; first = -1; last = -1; pat = 8'd0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 4) begin
                set_lane(0, 6'd1, cyc, 32'd100, 5'd0, cyc[3:0]);
                set_lane(1, 6'd3, 32'hFFFF, cyc + 16, 5'd0, 4'd8 + cyc[3:0]);
                req_valid = 2'b11;
            end else begin
                req_valid = 2'b00;
            end
            @(negedge clk);
            if (res_valid) begin
                if (cnt < 8) pat[cnt] = res_src;
                cnt++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(posedge clk); #1;
        end
        check("cont_count", cnt, 8);
        check("cont_consecutive", last - first, 7);
        check("cont_rr_pattern", pat, 8'hAA);

        // backpressure: held result stays stable for 5 cycles, then 1/cycle
        res_ready = 1'b0;
        set_lane(0, 6'd1, 32'd10, 32'd20, 5'd0, 4'd1);
        req_valid = 2'b01;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 6'd2, 32'd50, k, 5'd0, 4'd2 + k[3:0]);
            set_lane(1, 6'd4, 32'd3, 32'd0, k[4:0], 4'd10 + k[3:0]);
            req_valid = (k < 2) ? 2'b11 : 2'b01;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_allow", alu_allow, 1'b0);
            check("bp_valid", res_valid, 1'b1);
            check("bp_data_stable", res_data, 32'd30);
            check("bp_tag_stable", res_tag, 4'd1);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        cnt = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(negedge clk);
            if (res_valid) begin
                cnt++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(posedge clk); #1;
        end
        check("bp_count", cnt, 6);
        check("bp_consecutive", last - first, 5);

        // full/overflow: DEPTH+2 pushes on req1 while stalled
        res_ready = 1'b0;
        set_lane(0, 6'd1, 32'd1, 32'd2, 5'd0, 4'd5);
        req_valid = 2'b01;
        @(posedge clk); #1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            set_lane(1, 6'd1, 32'd1000, k, 5'd0, k[3:0]);
            req_valid = 2'b10;
            @(negedge clk);
            check("ovf_ready", req_ready[1], (k < DEPTH));
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        res_ready = 1'b1;
        cnt = 0; cnt1 = 0; tags = 16'd0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (res_valid) begin
                cnt++;
                if (res_src) begin
                    if (cnt1 < 4) tags[cnt1*4 +: 4] = res_tag;
                    cnt1++;
                end
            end
            @(posedge clk); #1;
        end
        check("ovf_total", cnt, DEPTH + 1);
        check("ovf_req1_count", cnt1, DEPTH);
        check("ovf_order", tags, 16'h3210);

        // flush: queued ops dropped, held result still delivered
        res_ready = 1'b0;
        set_lane(0, 6'd1, 32'd1, 32'd1, 5'd0, 4'd7);
        req_valid = 2'b01;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            set_lane(1, 6'd3, 32'd5, 32'd6, 5'd0, 4'd1 + k[3:0]);
            req_valid = 2'b10;
            @(posedge clk); #1;
        end
        set_lane(0, 6'd1, 32'd9, 32'd9, 5'd0, 4'd12);
        req_valid = 2'b01;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b1;
        cnt = 0; tags = 16'd0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (res_valid) begin
                if (cnt == 0) tags[3:0] = res_tag;
                cnt++;
            end
            @(posedge clk); #1;
        end
        check("flush_count", cnt, 1);
        check("flush_held_tag", tags[3:0], 4'd7);

        // async reset mid-stream, between clock edges
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 6'd1, 32'd3, k, 5'd0, 4'd13);
            set_lane(1, 6'd1, 32'd4, k, 5'd0, 4'd14);
            req_valid = 2'b11;
            @(posedge clk); #1;
        end
        check("exc_sticky", exc_seen, 1'b1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("arst_res_valid", res_valid, 1'b0);
        check("arst_alu_allow", alu_allow, 1'b0);
        check("arst_req_ready", req_ready, 2'b11);
        check("arst_res_src", res_src, 1'b0);
        check("arst_res_tag", res_tag, 4'd0);
        check("arst_exc_seen", exc_seen, 1'b0);
        req_valid = 2'b00;
        @(posedge clk); #1;
        check("arst_allow_held", alu_allow, 1'b0);
        reset = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (res_valid) cnt++;
            @(posedge clk); #1;
        end
        check("arst_no_result", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
